// File: rtl/simon_pkg.sv
// Shared definitions for the Simon score keeper: state encoding and widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package simon_pkg;

   localparam int SCORE_W = 6;
   localparam int CLK_HZ  = 5000000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      OVER = 2'd2
   } state_t;

endpackage

// File: rtl/simon_sat_counter.sv
// Saturating up-counter with a synchronous clear-to-constant, used for score and round.
// Latency: count changes one cycle after clear/inc.
// Backpressure: none; inc beyond MAX_VAL is absorbed, the count holds at MAX_VAL.
module simon_sat_counter #(
   parameter int WIDTH     = 6,
   parameter int MAX_VAL   = 63,
   parameter int CLEAR_VAL = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Next count: clear wins over inc; inc stops at the ceiling instead of wrapping.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = WIDTH'(CLEAR_VAL);
      end else if (inc && (count_q < WIDTH'(MAX_VAL))) begin
         count_d = count_q + 1'b1;
      end
   end

   // Count register; reset always returns to zero regardless of CLEAR_VAL.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/simon_score_keeper.sv
// Simon game score/round tracker with game-over hold; optional best score via SIMON_HIGH_SCORE_EN.
// Latency: every output changes one cycle after the input pulse that causes it.
// Backpressure: none; pulses arriving in states that ignore them are dropped.
module simon_score_keeper
   import simon_pkg::*;
#(
   parameter int MAX_SCORE   = 63,
   parameter int HOLD_CYCLES = CLK_HZ
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               round_pass,
   input  logic               round_fail,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] number,
   output logic               playing,
   output logic               game_over
);

   localparam int TMR_W = $clog2(HOLD_CYCLES + 1);

   state_t             state_q;
   state_t             state_d;
   logic [TMR_W-1:0]   timer_q;
   logic [TMR_W-1:0]   timer_d;
   logic               cnt_clr;
   logic               cnt_inc;
   logic [SCORE_W-1:0] score_q;
   logic [SCORE_W-1:0] round_q;

   // Score and round share clear/inc; round restarts at 1 on a new game.
   simon_sat_counter #(
      .WIDTH     (SCORE_W),
      .MAX_VAL   (MAX_SCORE),
      .CLEAR_VAL (0)
   ) u_score (
      .clk   (clk),
      .reset (reset),
      .clear (cnt_clr),
      .inc   (cnt_inc),
      .count (score_q)
   );

   simon_sat_counter #(
      .WIDTH     (SCORE_W),
      .MAX_VAL   (MAX_SCORE),
      .CLEAR_VAL (1)
   ) u_round (
      .clk   (clk),
      .reset (reset),
      .clear (cnt_clr),
      .inc   (cnt_inc),
      .count (round_q)
   );

   // Next state: start restarts from any state, fail beats pass, OVER counts down to IDLE.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = PLAY;
               cnt_clr = 1'b1;
            end
         end
         PLAY: begin
            if (start) begin
               cnt_clr = 1'b1;
            end else if (round_fail) begin
               state_d = OVER;
               timer_d = TMR_W'(HOLD_CYCLES - 1);
            end else if (round_pass) begin
               cnt_inc = 1'b1;
            end
         end
         OVER: begin
            if (start) begin
               state_d = PLAY;
               cnt_clr = 1'b1;
            end else if (timer_q == '0) begin
               state_d = IDLE;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and hold-timer registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
      end
   end

`ifdef SIMON_HIGH_SCORE_EN
   logic [SCORE_W-1:0] best_q;
   logic [SCORE_W-1:0] best_d;

   // Capture a new best only at the moment a game ends.
   always_comb begin
      best_d = best_q;
      if ((state_q == PLAY) && (state_d == OVER) && (score_q > best_q)) begin
         best_d = score_q;
      end
   end

   // Best-score register, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         best_q <= '0;
      end else begin
         best_q <= best_d;
      end
   end

   assign number = (state_q == PLAY) ? round_q : best_q;
`else
   assign number = round_q;
`endif

   assign score     = score_q;
   assign playing   = (state_q == PLAY);
   assign game_over = (state_q == OVER);

endmodule

// File: tb/tb_simon_score_keeper.sv
`timescale 1ns/1ps
module tb_simon_score_keeper;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       round_pass = 1'b0;
   logic       round_fail = 1'b0;
   logic [5:0] score;
   logic [5:0] number;
   logic       playing;
   logic       game_over;

   simon_score_keeper #(
      .MAX_SCORE   (5),
      .HOLD_CYCLES (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .round_pass (round_pass),
      .round_fail (round_fail),
      .score      (score),
      .number     (number),
      .playing    (playing),
      .game_over  (game_over)
   );

   always #100 clk = ~clk;

   typedef struct {
      int         due;
      logic [5:0] sc;
      logic [5:0] nm;
      logic       pl;
      logic       ov;
      string      name;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: outputs are settled at the falling edge; compare any entry that is due.
   initial begin
      forever begin
         @(negedge clk);
         while (q.size() > 0 && q[0].due <= cyc) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (e.due != cyc ||
                score !== e.sc || number !== e.nm ||
                playing !== e.pl || game_over !== e.ov) begin
               errors++;
               $display("FAIL %s: got score=%0d number=%0d playing=%b game_over=%b, want score=%0d number=%0d playing=%b game_over=%b (cycle %0d due %0d)",
                        e.name, score, number, playing, game_over,
                        e.sc, e.nm, e.pl, e.ov, cyc, e.due);
            end
         end
      end
   end

   // Drive one cycle of inputs and queue the outputs expected after the next edge.
   task automatic apply(input logic st, input logic pa, input logic fa, input logic rs,
                        input int sc, input int n_plain, input int n_hs,
                        input logic pl, input logic ov, input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      start      = st;
      round_pass = pa;
      round_fail = fa;
      reset      = rs;
      e.due  = cyc + 1;
      e.sc   = 6'(sc);
`ifdef SIMON_HIGH_SCORE_EN
      e.nm   = 6'(n_hs);
`else
      e.nm   = 6'(n_plain);
`endif
      e.pl   = pl;
      e.ov   = ov;
      e.name = nm;
      q.push_back(e);
   endtask

   initial begin
      // st pa fa rs  score n_plain n_hs play over
      apply(0, 0, 0, 1, 0, 0, 0, 0, 0, "reset");
      apply(0, 1, 0, 0, 0, 0, 0, 0, 0, "idle_pass_ignored");
      apply(1, 0, 0, 0, 0, 1, 1, 1, 0, "start");
      apply(0, 1, 0, 0, 1, 2, 2, 1, 0, "pass1");
      apply(0, 1, 0, 0, 2, 3, 3, 1, 0, "pass2");
      apply(0, 1, 0, 0, 3, 4, 4, 1, 0, "pass3");
      apply(0, 1, 0, 0, 4, 5, 5, 1, 0, "pass4");
      apply(0, 1, 0, 0, 5, 5, 5, 1, 0, "pass5_sat");
      apply(0, 1, 0, 0, 5, 5, 5, 1, 0, "pass6_sat");
      apply(0, 1, 0, 0, 5, 5, 5, 1, 0, "pass7_sat");
      apply(0, 0, 1, 0, 5, 5, 5, 0, 1, "fail_over1");
      apply(0, 0, 0, 0, 5, 5, 5, 0, 1, "over2");
      apply(0, 1, 0, 0, 5, 5, 5, 0, 1, "over3_pass_ignored");
      apply(0, 0, 0, 0, 5, 5, 5, 0, 1, "over4");
      apply(0, 0, 0, 0, 5, 5, 5, 0, 0, "hold_done_idle");
      apply(0, 0, 1, 0, 5, 5, 5, 0, 0, "idle_fail_ignored");
      apply(1, 0, 0, 0, 0, 1, 1, 1, 0, "start2");
      apply(0, 1, 0, 0, 1, 2, 2, 1, 0, "g2_pass1");
      apply(0, 1, 0, 0, 2, 3, 3, 1, 0, "g2_pass2");
      apply(0, 1, 1, 0, 2, 3, 5, 0, 1, "pass_fail_same_cycle");
      apply(0, 0, 0, 0, 2, 3, 5, 0, 1, "g2_over2");
      apply(1, 0, 0, 0, 0, 1, 1, 1, 0, "start_in_over");
      apply(0, 1, 0, 0, 1, 2, 2, 1, 0, "g3_pass1");
      apply(1, 1, 0, 0, 0, 1, 1, 1, 0, "start_pass_restart");
      apply(0, 1, 0, 0, 1, 2, 2, 1, 0, "g4_pass1");
      apply(0, 1, 0, 0, 2, 3, 3, 1, 0, "g4_pass2");
      apply(1, 0, 1, 0, 0, 1, 1, 1, 0, "start_fail_restart");
      apply(0, 1, 0, 0, 1, 2, 2, 1, 0, "g5_pass1");
      apply(0, 1, 0, 0, 2, 3, 3, 1, 0, "g5_pass2");
      apply(0, 1, 0, 0, 3, 4, 4, 1, 0, "g5_pass3");
      apply(0, 1, 0, 1, 0, 0, 0, 0, 0, "reset_mid_play");
      apply(0, 1, 0, 0, 0, 0, 0, 0, 0, "post_reset_pass_ignored");
      apply(0, 0, 1, 0, 0, 0, 0, 0, 0, "post_reset_fail_ignored");
      apply(1, 0, 0, 0, 0, 1, 1, 1, 0, "start6");
      apply(0, 1, 0, 0, 1, 2, 2, 1, 0, "g6_pass1");
      apply(0, 1, 0, 0, 2, 3, 3, 1, 0, "g6_pass2");
      apply(0, 0, 1, 0, 2, 3, 2, 0, 1, "g6_fail_best");
      apply(1, 1, 0, 0, 0, 1, 1, 1, 0, "start_pass_in_over");
      apply(0, 1, 0, 0, 1, 2, 2, 1, 0, "g7_pass1");
      apply(0, 0, 1, 0, 1, 2, 2, 0, 1, "g7_fail_no_best");
      apply(0, 0, 0, 0, 1, 2, 2, 0, 1, "g7_over2");
      apply(0, 0, 0, 0, 1, 2, 2, 0, 1, "g7_over3");
      apply(0, 0, 0, 0, 1, 2, 2, 0, 1, "g7_over4");
      apply(0, 0, 0, 0, 1, 2, 2, 0, 0, "g7_idle");
      apply(0, 0, 0, 1, 0, 0, 0, 0, 0, "reset_in_idle");
      apply(1, 0, 0, 0, 0, 1, 1, 1, 0, "start8");
      apply(0, 0, 1, 0, 0, 1, 0, 0, 1, "g8_fail_zero");
      apply(0, 1, 0, 1, 0, 0, 0, 0, 0, "reset_mid_over");
      apply(0, 0, 0, 0, 0, 0, 0, 0, 0, "idle_after_reset");

      @(posedge clk);
      #1;
      start      = 1'b0;
      round_pass = 1'b0;
      round_fail = 1'b0;
      reset      = 1'b0;

      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/simon_score_keeper.md
SIMON_SCORE_KEEPER -- requirements
Module: simon_score_keeper

Interface
REQ-001 SHALL have parameter MAX_SCORE, default 63: saturation ceiling for score and round; must be 1..63.
REQ-002 SHALL have parameter HOLD_CYCLES, default 5000000: game-over hold time in clk cycles (1 s at 5 MHz); must be >= 1.
REQ-003 SHALL have port clk, input, 1: single clock, 5 MHz.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: one-cycle pulse that begins a new game.
REQ-006 SHALL have port round_pass, input, 1: one-cycle pulse; player repeated the sequence correctly.
REQ-007 SHALL have port round_fail, input, 1: one-cycle pulse; player made an error.
REQ-008 SHALL have port score, output, 6: current game score; feeds display_control.score.
REQ-009 SHALL have port number, output, 6: left-hand display value; feeds display_control.number.
REQ-010 SHALL have port playing, output, 1: high in PLAY.
REQ-011 SHALL have port game_over, output, 1: high in OVER.

Function
REQ-012 SHALL implement FSM states IDLE, PLAY, OVER; all outputs registered (1-cycle latency from input pulse to output change).
REQ-013 IDLE: start -> PLAY with score<=0, round<=1; round_pass and round_fail ignored.
REQ-014 PLAY: round_pass -> score<=min(score+1, MAX_SCORE), round<=min(round+1, MAX_SCORE); state unchanged.
REQ-015 PLAY: round_fail -> OVER, hold timer loaded with HOLD_CYCLES-1; score and round frozen.
REQ-016 PLAY: round_pass and round_fail in the same cycle -> round_fail wins; score not incremented.
REQ-017 PLAY: start (with or without pass/fail) -> restart: score<=0, round<=1, stay in PLAY; start has highest priority in every state.
REQ-018 OVER: timer decrements each cycle; on the cycle timer==0 -> IDLE; score retained for display until the next start.
REQ-019 OVER: start -> PLAY immediately (REQ-013 values); round_pass and round_fail ignored.
REQ-020 At saturation, further round_pass SHALL leave score/round at MAX_SCORE without wrap.
REQ-021 Timer width SHALL be $clog2(HOLD_CYCLES+1) bits; no overflow for any legal HOLD_CYCLES.
REQ-022 Without HIGH_SCORE_EN, number SHALL equal the current round (0 in IDLE after reset).

Reset
REQ-023 reset SHALL force state IDLE, score=0, round=0, number=0, timer=0, playing=0, game_over=0, best=0.
REQ-024 reset SHALL take priority over all inputs, including mid-PLAY and mid-OVER; the first non-reset cycle behaves as IDLE.

Configuration
REQ-025 Macro SIMON_HIGH_SCORE_EN defined: a 6-bit best register SHALL load score on the PLAY->OVER transition when score > best; number SHALL show best in IDLE/OVER and round in PLAY; best cleared only by reset.
REQ-026 Macro SIMON_HIGH_SCORE_EN undefined: no best register SHALL exist; number behaves per REQ-022.

Structure
REQ-027 Shared package simon_pkg SHALL hold the state encoding (IDLE=2'd0, PLAY=2'd1, OVER=2'd2), SCORE_W=6, and CLK_HZ=5000000.
REQ-028 One sub-module, simon_sat_counter (width, max, clear, inc), SHALL be instantiated twice, for score and round; the hold timer stays inline.

Verification
REQ-029 reset, then start, then 3 round_pass pulses -> score=3, number=4, playing=1, one cycle after each pulse.
REQ-030 MAX_SCORE=5: start, then 8 round_pass -> score=5, round=5, no wrap.
REQ-031 round_pass and round_fail together in PLAY with score=2 -> score=2, game_over=1 next cycle.
REQ-032 HOLD_CYCLES=4: round_fail -> game_over high exactly 4 cycles, then IDLE; start in cycle 2 of OVER -> playing=1, score=0 next cycle.
REQ-033 SIMON_HIGH_SCORE_EN: game 1 scores 7 -> fail; game 2 scores 3 -> fail -> number=7 in OVER; reset -> number=0.
REQ-034 reset asserted mid-PLAY with score=9 -> all outputs 0 next cycle; round_pass then ignored until start.
